keypad_password_checker: RTL

//  Keypad front end that generates the door-lock controller's event inputs: is_star_pressed, correct, reset, initialize.

---
 rtl/keypad_password_checker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/keypad_password_checker.sv
// Keypad front end for the door-lock controller: buffers BCD digits, checks or reprograms the password.
// Optional lockout timer in state 111 is built when LOCKOUT_TIMER_EN is defined.
module keypad_password_checker #(
  parameter int          PW_LEN         = 4,
  parameter logic [31:0] DEFAULT_PW     = 32'h0000,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [2:0] lock_state,
  output logic       is_star_pressed,
  output logic       correct,
  output logic       reset_req,
  output logic       init_req,
  output logic [3:0] digit_count,
  output logic       lockout_active
);

  // key_valid is a strobe with no back-pressure: every cycle it is high is one key.
  localparam int         PW_W     = 4 * PW_LEN;
  localparam logic [3:0] LEN      = 4'(PW_LEN);
  localparam logic [3:0] LEN_P1   = 4'(PW_LEN + 1);
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [2:0] {
    ST_OFF    = 3'b000,
    ST_ON     = 3'b001,
    ST_WRONG1 = 3'b010,
    ST_WRONG2 = 3'b011,
    ST_ANSWER = 3'b100,
    ST_RESET  = 3'b101,
    ST_UNUSED = 3'b110,
    ST_LOCK   = 3'b111
  } lock_state_e;

  lock_state_e       mode;
  logic [2:0]        prev_q;
  logic [3:0]        cnt_q, cnt_d, cnt_base;
  logic [PW_W-1:0]   entry_q, entry_d;
  logic [PW_W-1:0]   pw_q, pw_d;
  logic              star_d, correct_d, reset_req_d, init_req_d;
  logic              mode_change, blocked, key_ok, is_digit;

  assign mode        = lock_state_e'(lock_state);
  assign mode_change = (lock_state != prev_q);
  // Buffer contents past cnt are don't-care, so clearing the buffer only clears the count.
  assign cnt_base    = mode_change ? 4'd0 : cnt_q;
  assign is_digit    = (key_code <= 4'd9);
  assign key_ok      = key_valid && !blocked;

`ifdef LOCKOUT_TIMER_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lock_cnt_q;

  // The entry edge itself already counts as locked out.
  assign blocked        = (mode == ST_LOCK) && (mode_change || (lock_cnt_q != '0));
  assign lockout_active = (lock_cnt_q != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                lock_cnt_q <= '0;
    else if (mode != ST_LOCK)    lock_cnt_q <= '0;
    else if (mode_change)        lock_cnt_q <= LW'(LOCKOUT_CYCLES);
    else if (lock_cnt_q != '0)   lock_cnt_q <= lock_cnt_q - LW'(1);
  end
`else
  assign blocked        = 1'b0;
  assign lockout_active = 1'b0;
`endif

  always_comb begin
    cnt_d       = cnt_base;
    entry_d     = entry_q;
    pw_d        = pw_q;
    star_d      = 1'b0;
    correct_d   = 1'b0;
    reset_req_d = 1'b0;
    init_req_d  = 1'b0;
    case (mode)
      ST_ON, ST_WRONG1, ST_WRONG2, ST_LOCK, ST_RESET: begin
        if (key_ok) begin
          if (is_digit) begin
            if (cnt_base < LEN) entry_d[4*cnt_base[2:0] +: 4] = key_code;
            if (cnt_base != LEN_P1) cnt_d = cnt_base + 4'd1;
          end else if (key_code == KEY_HASH) begin
            cnt_d = 4'd0;
          end else if (key_code == KEY_STAR) begin
            cnt_d = 4'd0;
            if (mode == ST_RESET) begin
              if (cnt_base == LEN) begin
                pw_d       = entry_q;
                init_req_d = 1'b1;
              end
            end else begin
              star_d    = 1'b1;
              correct_d = (cnt_base == LEN) && (entry_q == pw_q);
            end
          end
        end
      end
      ST_ANSWER: begin
        if (key_ok && key_code == KEY_HASH) reset_req_d = 1'b1;
      end
      default: cnt_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q          <= 3'b000;
      cnt_q           <= 4'd0;
      entry_q         <= '0;
      pw_q            <= DEFAULT_PW[PW_W-1:0];
      is_star_pressed <= 1'b0;
      correct         <= 1'b0;
      reset_req       <= 1'b0;
      init_req        <= 1'b0;
    end else begin
      prev_q          <= lock_state;
      cnt_q           <= cnt_d;
      entry_q         <= entry_d;
      pw_q            <= pw_d;
      is_star_pressed <= star_d;
      correct         <= correct_d;
      reset_req       <= reset_req_d;
      init_req        <= init_req_d;
    end
  end

  assign digit_count = cnt_q;

endmodule
